// File: rtl/if_id_fetch_stage_if.sv
// ============================================================================
// Module   : if_id_fetch_stage_if
// Brief    : Fetch-stage bundle: hazard/redirect controls, imem bus, IF/ID outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface if_id_fetch_stage_if #(
    parameter int N = 32
);
    logic         stall;
    logic         redirect;
    logic [N-1:0] redirect_pc;
    logic [N-1:0] imem_addr;
    logic         imem_req;
    logic [N-1:0] imem_rdata;
    logic         imem_ready;
    logic [N-1:0] pc;
    logic [N-1:0] ins_id;
    logic [N-1:0] pc_plus4_id;
    logic         valid_id;
    logic [N-1:0] fetch_count;

    // Fetch stage side
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata, imem_ready,
        output imem_addr, imem_req, pc, ins_id, pc_plus4_id, valid_id, fetch_count
    );

    // Environment side (hazard unit, imem, decoder)
    modport slave (
        output stall, redirect, redirect_pc, imem_rdata, imem_ready,
        input  imem_addr, imem_req, pc, ins_id, pc_plus4_id, valid_id, fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/if_id_fetch_stage.sv
// ============================================================================
// Module   : if_id_fetch_stage
// Brief    : PC register, instruction fetch and IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_id_fetch_stage #(
    parameter int          N        = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    if_id_fetch_stage_if.master bus
);

    localparam logic [N-1:0] c_PC_STEP = N'(4);

    logic [N-1:0] r_pc;
    logic [N-1:0] r_ins_id;
    logic [N-1:0] r_pc_plus4_id;
    logic         r_valid_id;
    logic [N-1:0] r_fetch_count;

    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_redirect_target;

    // Both wrap modulo 2^N by construction of the operand widths.
    assign w_pc_plus4        = r_pc + c_PC_STEP;
    assign w_redirect_target = {bus.redirect_pc[N-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= N'(RESET_PC);
            r_ins_id      <= N'(NOP_WORD);
            r_pc_plus4_id <= '0;
            r_valid_id    <= 1'b0;
            r_fetch_count <= '0;
        end else if (bus.redirect) begin
            // Redirect discards whatever is in flight, even under stall.
            r_pc          <= w_redirect_target;
            r_ins_id      <= N'(NOP_WORD);
            r_pc_plus4_id <= '0;
            r_valid_id    <= 1'b0;
        end else if (bus.stall) begin
            r_pc          <= r_pc;
        end else if (!bus.imem_ready) begin
            r_ins_id      <= N'(NOP_WORD);
            r_pc_plus4_id <= '0;
            r_valid_id    <= 1'b0;
        end else begin
            r_pc          <= w_pc_plus4;
            r_ins_id      <= bus.imem_rdata;
            r_pc_plus4_id <= w_pc_plus4;
            r_valid_id    <= 1'b1;
            r_fetch_count <= r_fetch_count + N'(1);
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.imem_req    = !rst && !bus.stall;
    assign bus.pc          = r_pc;
    assign bus.ins_id      = r_ins_id;
    assign bus.pc_plus4_id = r_pc_plus4_id;
    assign bus.valid_id    = r_valid_id;
    assign bus.fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_fetch_stage.sv
// ============================================================================
// Module   : tb_if_id_fetch_stage
// Brief    : Scoreboard bench for if_id_fetch_stage with an address-keyed imem.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_id_fetch_stage;

    localparam logic [31:0] c_KEY = 32'hA5A5_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    if_id_fetch_stage_if #(.N(32)) bus ();

    if_id_fetch_stage #(
        .N        (32),
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word derived from its address, so any fetch is traceable.
    always_comb bus.imem_rdata = bus.imem_addr ^ c_KEY;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pp4;
        logic        v;
        logic [31:0] fc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pc, m_ins, m_pp4, m_fc;
    logic        m_v;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic rs, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
        exp_t e;
        @(negedge clk);
        rst              = rs;
        bus.stall        = st;
        bus.redirect     = rd;
        bus.redirect_pc  = rpc;
        bus.imem_ready   = rdy;
        #1;
        check("imem_req",  {31'b0, bus.imem_req}, {31'b0, (!rs && !st)});
        check("imem_addr", bus.imem_addr, m_pc);
        if (rs) begin
            m_pc = 32'h0; m_ins = 32'h0; m_pp4 = 32'h0; m_v = 1'b0; m_fc = 32'h0;
        end else if (rd) begin
            m_pc = {rpc[31:2], 2'b00}; m_ins = 32'h0; m_pp4 = 32'h0; m_v = 1'b0;
        end else if (st) begin
            m_pc = m_pc;
        end else if (!rdy) begin
            m_ins = 32'h0; m_v = 1'b0;
        end else begin
            m_ins = m_pc ^ c_KEY; m_pp4 = m_pc + 32'd4; m_v = 1'b1;
            m_pc  = m_pc + 32'd4; m_fc  = m_fc + 32'd1;
        end
        e.pc = m_pc; e.ins = m_ins; e.pp4 = m_pp4; e.v = m_v; e.fc = m_fc;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("pc",          bus.pc,          e.pc);
        check("ins_id",      bus.ins_id,      e.ins);
        check("valid_id",    {31'b0, bus.valid_id}, {31'b0, e.v});
        check("fetch_count", bus.fetch_count, e.fc);
        if (!rdy && !rs && !rd && !st) begin
            // pc_plus4_id is not defined for memory-wait bubbles
        end else begin
            check("pc_plus4_id", bus.pc_plus4_id, e.pp4);
        end
    endtask

    initial begin
        logic [31:0] fc_before;
        n_checks = 0;
        n_errors = 0;
        m_pc = 32'h0; m_ins = 32'h0; m_pp4 = 32'h0; m_v = 1'b0; m_fc = 32'h0;
        rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0; bus.imem_ready = 1'b0;

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("rst_pc",    bus.pc,          32'h0);
        check("rst_valid", {31'b0, bus.valid_id}, 32'h0);

        // Free run: two accepts to reach pc=8
        step(0, 0, 0, 0, 1);
        check("run_ins0", bus.ins_id, 32'hA5A5_0000);
        step(0, 0, 0, 0, 1);
        check("run_ins1", bus.ins_id, 32'hA5A5_0004);
        check("run_pc8",  bus.pc,     32'h8);

        // Stall three cycles at pc=8
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
        check("stall_pc",  bus.pc,          32'h8);
        check("stall_ins", bus.ins_id,      32'hA5A5_0004);
        check("stall_fc",  bus.fetch_count, 32'd2);
        step(0, 0, 0, 0, 1);
        check("release_ins", bus.ins_id, 32'hA5A5_0008);
        step(0, 0, 0, 0, 1);
        check("run_pc10", bus.pc, 32'h10);
        check("run_fc4",  bus.fetch_count, 32'd4);

        // Redirect with misaligned target
        step(0, 0, 1, 32'h0000_0103, 1);
        check("redir_pc",    bus.pc,     32'h100);
        check("redir_valid", {31'b0, bus.valid_id}, 32'h0);
        check("redir_ins",   bus.ins_id, 32'h0);
        step(0, 0, 0, 0, 1);
        check("redir_ins2", bus.ins_id,      32'hA5A5_0100);
        check("redir_pp4",  bus.pc_plus4_id, 32'h104);

        // Redirect and stall together
        step(0, 1, 1, 32'h40, 1);
        check("rs_pc",    bus.pc, 32'h40);
        check("rs_valid", {31'b0, bus.valid_id}, 32'h0);

        // Memory wait states at pc=0x20
        step(0, 0, 1, 32'h20, 1);
        fc_before = bus.fetch_count;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("wait_pc",    bus.pc, 32'h20);
        check("wait_valid", {31'b0, bus.valid_id}, 32'h0);
        check("wait_ins",   bus.ins_id, 32'h0);
        step(0, 0, 0, 0, 1);
        check("wait_ins2", bus.ins_id,      32'hA5A5_0020);
        check("wait_fc",   bus.fetch_count, fc_before + 32'd1);

        // Wrap of pc+4 at the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_pc",  bus.pc,          32'h0);
        check("wrap_pp4", bus.pc_plus4_id, 32'h0);
        check("wrap_ins", bus.ins_id,      32'h5A5A_FFFC);

        // Reset during a memory wait
        step(0, 0, 1, 32'h80, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rmw_pc",    bus.pc,          32'h0);
        check("rmw_addr",  bus.imem_addr,   32'h0);
        check("rmw_fc",    bus.fetch_count, 32'h0);
        check("rmw_valid", {31'b0, bus.valid_id}, 32'h0);
        step(0, 0, 0, 0, 1);
        check("rmw_ins", bus.ins_id, 32'hA5A5_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
